alu_operand_stage: RTL and testbench

//  Decode-to-execute stage directly upstream of the ALU. Holds the 32x32 register

---
 rtl/alu_operand_stage.sv | 93 +++++++++
 tb/tb_alu_operand_stage.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: register file, operand forwarding, load-use hazard detection and ID/EX register feeding the ALU
module alu_operand_stage #(
  parameter bit IMM_SEXT = 1'b1
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [4:0]  id_shamt,
  input  logic [15:0] id_imm,
  input  logic [5:0]  id_alu_op,
  input  logic        id_use_imm,
  input  logic        id_use_shamt,
  input  logic        id_is_load,
  input  logic        id_reg_write,
  input  logic        flush,
  input  logic [31:0] alu_result,
  input  logic        mem_reg_write,
  input  logic [4:0]  mem_dest,
  input  logic [31:0] mem_data,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        id_stall,
  output logic        ex_valid,
  output logic        ex_reg_write,
  output logic        ex_is_load,
  output logic [4:0]  ex_dest,
  output logic [5:0]  ex_alu_op,
  output logic [31:0] ex_opA,
  output logic [31:0] ex_opB
);
  logic [31:0] regs [32];
  logic        ex_fwd, hazard, bubble;
  logic [31:0] rs_val, rt_val, imm_ext, op_a, op_b;

  assign ex_fwd  = ex_valid & ex_reg_write & ~ex_is_load;
  assign imm_ext = IMM_SEXT ? {{16{id_imm[15]}}, id_imm} : {16'b0, id_imm};

  // source values: EX beats MEM beats WB write-through beats the register file; r0 is hard zero
  always_comb begin
    rs_val = id_rs == 5'd0 ? 32'd0 :
             (ex_fwd && ex_dest == id_rs) ? alu_result :
             (mem_reg_write && mem_dest == id_rs) ? mem_data :
             (wb_we && wb_addr == id_rs) ? wb_data : regs[id_rs];
    rt_val = id_rt == 5'd0 ? 32'd0 :
             (ex_fwd && ex_dest == id_rt) ? alu_result :
             (mem_reg_write && mem_dest == id_rt) ? mem_data :
             (wb_we && wb_addr == id_rt) ? wb_data : regs[id_rt];
    op_a   = id_use_shamt ? {27'b0, id_shamt} : rs_val;
    op_b   = id_use_imm ? imm_ext : rt_val;
  end

  // a load in EX cannot forward yet, so any used source matching its dest must wait a cycle
  always_comb begin
    hazard   = id_valid & ex_valid & ex_is_load & (ex_dest != 5'd0) &
               ((~id_use_shamt & (ex_dest == id_rs)) | (~id_use_imm & (ex_dest == id_rt)));
    id_stall = hazard & ~flush;
    bubble   = flush | hazard | ~id_valid;
  end

  // register file write port; r0 writes are dropped
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (wb_we && wb_addr != 5'd0) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // ID/EX pipeline register: bubble on flush, hazard or empty slot
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst || bubble) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_is_load   <= 1'b0;
      ex_dest      <= 5'd0;
      ex_alu_op    <= 6'd0;
      ex_opA       <= 32'd0;
      ex_opB       <= 32'd0;
    end else begin
      ex_valid     <= 1'b1;
      ex_reg_write <= id_reg_write;
      ex_is_load   <= id_is_load;
      ex_dest      <= id_rd;
      ex_alu_op    <= id_alu_op;
      ex_opA       <= op_a;
      ex_opB       <= op_b;
    end
  end
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed and randomized checks of alu_operand_stage against a behavioural model
module tb_alu_operand_stage;
  logic        clk = 1'b0, nrst;
  logic        id_valid, id_use_imm, id_use_shamt, id_is_load, id_reg_write, flush;
  logic [4:0]  id_rs, id_rt, id_rd, id_shamt, mem_dest, wb_addr;
  logic [15:0] id_imm;
  logic [5:0]  id_alu_op;
  logic [31:0] alu_result, mem_data, wb_data;
  logic        mem_reg_write, wb_we;
  logic        id_stall, ex_valid, ex_reg_write, ex_is_load;
  logic [4:0]  ex_dest;
  logic [5:0]  ex_alu_op;
  logic [31:0] ex_opA, ex_opB;
  logic        id_stall0, ex_valid0, ex_reg_write0, ex_is_load0;
  logic [4:0]  ex_dest0;
  logic [5:0]  ex_alu_op0;
  logic [31:0] ex_opA0, ex_opB0;
  int          n_cmp = 0, n_bad = 0;
  logic        chk_en = 1'b0;

  always #5 clk = ~clk;

  alu_operand_stage #(.IMM_SEXT(1'b1)) u_dut (
    .clk(clk), .nrst(nrst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_shamt(id_shamt), .id_imm(id_imm), .id_alu_op(id_alu_op), .id_use_imm(id_use_imm),
    .id_use_shamt(id_use_shamt), .id_is_load(id_is_load), .id_reg_write(id_reg_write), .flush(flush),
    .alu_result(alu_result), .mem_reg_write(mem_reg_write), .mem_dest(mem_dest), .mem_data(mem_data),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .id_stall(id_stall), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load), .ex_dest(ex_dest), .ex_alu_op(ex_alu_op),
    .ex_opA(ex_opA), .ex_opB(ex_opB));

  alu_operand_stage #(.IMM_SEXT(1'b0)) u_dut0 (
    .clk(clk), .nrst(nrst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_shamt(id_shamt), .id_imm(id_imm), .id_alu_op(id_alu_op), .id_use_imm(id_use_imm),
    .id_use_shamt(id_use_shamt), .id_is_load(id_is_load), .id_reg_write(id_reg_write), .flush(flush),
    .alu_result(alu_result), .mem_reg_write(mem_reg_write), .mem_dest(mem_dest), .mem_data(mem_data),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .id_stall(id_stall0), .ex_valid(ex_valid0),
    .ex_reg_write(ex_reg_write0), .ex_is_load(ex_is_load0), .ex_dest(ex_dest0), .ex_alu_op(ex_alu_op0),
    .ex_opA(ex_opA0), .ex_opB(ex_opB0));

  typedef struct packed {
    logic        v, rw, ld;
    logic [4:0]  d;
    logic [5:0]  op;
    logic [31:0] a, b;
  } ex_t;

  ex_t         m, nx;
  logic [31:0] m_regs [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // newest producer of a register value wins; a load still in EX has no value to give
  function automatic logic [31:0] m_src(input logic [4:0] s);
    if (s == 0) return 32'd0;
    if (m.v && m.rw && !m.ld && m.d == s) return alu_result;
    if (mem_reg_write && mem_dest == s) return mem_data;
    if (wb_we && wb_addr == s) return wb_data;
    return m_regs[s];
  endfunction

  function automatic logic m_haz();
    return id_valid && m.v && m.ld && m.d != 0 &&
           ((!id_use_shamt && m.d == id_rs) || (!id_use_imm && m.d == id_rt));
  endfunction

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m = '0;
      foreach (m_regs[i]) m_regs[i] = 32'd0;
    end else begin
      nx = '0;
      if (id_valid && !flush && !m_haz()) begin
        nx.v  = 1'b1;
        nx.rw = id_reg_write;
        nx.ld = id_is_load;
        nx.d  = id_rd;
        nx.op = id_alu_op;
        nx.a  = id_use_shamt ? 32'(id_shamt) : m_src(id_rs);
        nx.b  = id_use_imm ? 32'(signed'(id_imm)) : m_src(id_rt);
      end
      if (wb_we && wb_addr != 0) m_regs[wb_addr] = wb_data;
      m = nx;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ex_valid", 32'(ex_valid), 32'(m.v));
      chk("ex_reg_write", 32'(ex_reg_write), 32'(m.rw));
      chk("ex_is_load", 32'(ex_is_load), 32'(m.ld));
      chk("ex_dest", 32'(ex_dest), 32'(m.d));
      chk("ex_alu_op", 32'(ex_alu_op), 32'(m.op));
      chk("ex_opA", ex_opA, m.a);
      chk("ex_opB", ex_opB, m.b);
      chk("id_stall", 32'(id_stall), 32'(m_haz() && !flush));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    {id_valid, id_use_imm, id_use_shamt, id_is_load, id_reg_write, flush} = '0;
    {id_rs, id_rt, id_rd, id_shamt, id_imm, id_alu_op} = '0;
    {alu_result, mem_reg_write, mem_dest, mem_data, wb_we, wb_addr, wb_data} = '0;
  endtask

  task automatic dec(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                     input logic [5:0] op, input logic ui, input logic us, input logic ld,
                     input logic rw, input logic [4:0] sh, input logic [15:0] im);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_alu_op = op;
    id_use_imm = ui; id_use_shamt = us; id_is_load = ld; id_reg_write = rw;
    id_shamt = sh; id_imm = im;
  endtask

  initial begin
    nrst = 1'b0;
    idle();
    repeat (2) cyc();
    nrst = 1'b1;
    chk_en = 1'b1;
    wb_we = 1; wb_addr = 5; wb_data = 32'h1234;
    dec(1, 5, 0, 1, 6'h20, 1, 0, 0, 1, 0, 16'h0);
    cyc();
    chk("wb_bypass", ex_opA, 32'h1234);
    chk("model_wb_bypass", m.a, 32'h1234);
    idle();
    dec(1, 0, 0, 3, 6'h20, 1, 0, 0, 1, 0, 16'h0);
    cyc();
    alu_result = 32'hA; mem_reg_write = 1; mem_dest = 3; mem_data = 32'hB;
    dec(1, 3, 0, 8, 6'h20, 1, 0, 0, 1, 0, 16'h0);
    cyc();
    chk("ex_over_mem", ex_opA, 32'hA);
    chk("model_ex_over_mem", m.a, 32'hA);
    idle();
    dec(1, 0, 0, 4, 6'h23, 1, 0, 1, 1, 0, 16'h0);
    cyc();
    dec(1, 0, 4, 9, 6'h20, 0, 0, 0, 1, 0, 16'h0);
    #1 chk("load_use_stall", 32'(id_stall), 32'd1);
    cyc();
    chk("load_use_bubble", 32'(ex_valid), 32'd0);
    mem_reg_write = 1; mem_dest = 4; mem_data = 32'h55;
    #1 chk("load_use_released", 32'(id_stall), 32'd0);
    cyc();
    chk("load_use_mem_fwd", ex_opB, 32'h55);
    chk("load_use_valid", 32'(ex_valid), 32'd1);
    chk("model_load_use", m.b, 32'h55);
    idle();
    wb_we = 1; wb_addr = 2; wb_data = 32'd1;
    cyc();
    idle();
    dec(1, 0, 2, 10, 6'h00, 0, 1, 0, 1, 4, 16'h0);
    cyc();
    chk("shamt_opA", ex_opA, 32'd4);
    chk("shamt_opB", ex_opB, 32'd1);
    dec(1, 0, 0, 11, 6'h08, 1, 0, 0, 1, 0, 16'hFFFF);
    cyc();
    chk("imm_sext", ex_opB, 32'hFFFF_FFFF);
    chk("imm_zext", ex_opB0, 32'h0000_FFFF);
    chk("model_imm_sext", m.b, 32'hFFFF_FFFF);
    idle();
    wb_we = 1; wb_addr = 0; wb_data = 32'd5;
    dec(1, 0, 0, 0, 6'h20, 0, 0, 0, 1, 0, 16'h0);
    cyc();
    chk("r0_wb_bypass", ex_opA, 32'd0);
    wb_we = 0; alu_result = 32'd77;
    dec(1, 0, 0, 12, 6'h20, 0, 0, 0, 1, 0, 16'h0);
    cyc();
    chk("r0_no_ex_fwd_a", ex_opA, 32'd0);
    chk("r0_no_ex_fwd_b", ex_opB, 32'd0);
    idle();
    dec(1, 0, 0, 0, 6'h23, 1, 0, 1, 1, 0, 16'h0);
    cyc();
    dec(1, 0, 0, 15, 6'h20, 0, 0, 0, 1, 0, 16'h0);
    #1 chk("r0_no_hazard", 32'(id_stall), 32'd0);
    cyc();
    chk("r0_no_hazard_issue", 32'(ex_valid), 32'd1);
    idle();
    dec(1, 0, 0, 6, 6'h23, 1, 0, 1, 1, 0, 16'h0);
    cyc();
    dec(1, 6, 0, 13, 6'h20, 1, 0, 0, 1, 0, 16'h0);
    flush = 1;
    #1 chk("flush_hazard_stall", 32'(id_stall), 32'd0);
    cyc();
    chk("flush_hazard_bubble", 32'(ex_valid), 32'd0);
    idle();
    wb_we = 1; wb_addr = 7; wb_data = 32'hDEAD;
    cyc();
    idle();
    dec(1, 7, 0, 14, 6'h20, 1, 0, 0, 1, 0, 16'h0);
    cyc();
    chk("pre_reset_valid", 32'(ex_valid), 32'd1);
    chk("pre_reset_r7", ex_opA, 32'hDEAD);
    #2 nrst = 1'b0;
    #1 chk("reset_valid", 32'(ex_valid), 32'd0);
    chk("reset_opA", ex_opA, 32'd0);
    chk("reset_dest", 32'(ex_dest), 32'd0);
    cyc();
    nrst = 1'b1;
    cyc();
    chk("reset_r7_zero", ex_opA, 32'd0);
    chk("reset_r7_valid", 32'(ex_valid), 32'd1);
    for (int k = 0; k < 3000; k++) begin
      nrst = ($urandom_range(199) != 0);
      id_valid = ($urandom_range(9) < 8);
      id_rs = 5'($urandom_range(7));
      id_rt = 5'($urandom_range(7));
      id_rd = 5'($urandom_range(7));
      id_shamt = 5'($urandom);
      id_imm = 16'($urandom);
      id_alu_op = 6'($urandom);
      id_use_imm = ($urandom_range(3) == 0);
      id_use_shamt = ($urandom_range(4) == 0);
      id_is_load = ($urandom_range(2) == 0);
      id_reg_write = ($urandom_range(4) != 0);
      flush = ($urandom_range(9) == 0);
      alu_result = $urandom;
      mem_reg_write = $urandom_range(1) == 1;
      mem_dest = 5'($urandom_range(7));
      mem_data = $urandom;
      wb_we = $urandom_range(1) == 1;
      wb_addr = 5'($urandom_range(7));
      wb_data = $urandom;
      cyc();
    end
    nrst = 1'b1;
    idle();
    cyc();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
